// File: rtl/q_proj_window_mac.sv
// Sliding KERNEL-tap signed MAC over padded rows popped from the Q-projection byte FIFO.
// Results leave through a 2-entry buffer on a valid/ready stream; done pulses once per job.
module q_proj_window_mac #(
  parameter int DATA_WIDTH = 8,
  parameter int KERNEL     = 3,
  parameter int ROW_LEN    = 7,
  parameter int NUM_ROWS   = 4,
  parameter int ACC_WIDTH  = 20
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [KERNEL*DATA_WIDTH-1:0] weights,
  input  logic                         fifo_empty,
  output logic                         fifo_read_en,
  input  logic [DATA_WIDTH-1:0]        fifo_read_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [ACC_WIDTH-1:0]         out_data,
  output logic                         out_last,
  output logic                         busy,
  output logic                         done
);

  localparam int TOTAL = ROW_LEN * NUM_ROWS;
  localparam int PW    = $clog2(TOTAL + 1);
  localparam int BW    = $clog2(ROW_LEN);
  localparam int RW    = $clog2(NUM_ROWS + 1);
  localparam int PRODW = 2 * DATA_WIDTH;
  localparam logic [PW-1:0] TOTAL_C   = PW'(TOTAL);
  localparam logic [BW-1:0] LAST_BYTE = BW'(ROW_LEN - 1);
  localparam logic [BW-1:0] FIRST_OUT = BW'(KERNEL - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;
  typedef logic [KERNEL-1:0][DATA_WIDTH-1:0] vec_t;

  state_t               state_q, state_d;
  vec_t                 w_q, w_d, win_q, win_d, win_next;
  logic [PW-1:0]        pops_q, pops_d;
  logic [BW-1:0]        byte_cnt_q, byte_cnt_d;
  logic [RW-1:0]        row_cnt_q, row_cnt_d;
  logic                 rd_pend_q;
  logic [ACC_WIDTH-1:0] buf_data_q [2];
  logic [1:0]           buf_last_q;
  logic                 wr_ptr_q, rd_ptr_q;
  logic [1:0]           occ_q;

  logic                        push, row_end, out_pop, room;
  logic signed [ACC_WIDTH-1:0] mac_res;

  // Signed DWxDW products, each sign-extended to ACC_WIDTH before summing; wraps, never saturates.
  function automatic logic signed [ACC_WIDTH-1:0] mac_f(input vec_t x, input vec_t w);
    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [PRODW-1:0]     prod;
    acc = '0;
    for (int k = 0; k < KERNEL; k++) begin
      prod = $signed(x[k]) * $signed(w[k]);
      acc  = acc + {{(ACC_WIDTH-PRODW){prod[PRODW-1]}}, prod};
    end
    return acc;
  endfunction

  always_comb begin
    for (int k = 0; k < KERNEL - 1; k++) win_next[k] = win_q[k+1];
    win_next[KERNEL-1] = fifo_read_data;
  end

  assign mac_res   = mac_f(win_next, w_q);
  assign push      = rd_pend_q && (byte_cnt_q >= FIRST_OUT);
  assign row_end   = rd_pend_q && (byte_cnt_q == LAST_BYTE);
  assign out_valid = (occ_q != 2'd0);
  assign out_pop   = out_valid && out_ready;
  assign out_data  = buf_data_q[rd_ptr_q];
  assign out_last  = buf_last_q[rd_ptr_q];
  assign busy      = (state_q == S_RUN) || (state_q == S_FLUSH);
  assign done      = (state_q == S_DONE);

  // A pop is allowed only if the result it may produce still fits next to the ones held or in flight.
  assign room = ({1'b0, occ_q} + {2'b00, rd_pend_q}) < (3'd2 + {2'b00, out_pop});
  assign fifo_read_en = (state_q == S_RUN) && !fifo_empty && (pops_q < TOTAL_C) && room;

  always_comb begin
    state_d    = state_q;
    w_d        = w_q;
    win_d      = win_q;
    pops_d     = pops_q;
    byte_cnt_d = byte_cnt_q;
    row_cnt_d  = row_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_RUN;
          w_d        = weights;
          win_d      = '0;
          pops_d     = '0;
          byte_cnt_d = '0;
          row_cnt_d  = '0;
        end
      end
      S_RUN:   if (pops_q == TOTAL_C) state_d = S_FLUSH;
      S_FLUSH: if (!rd_pend_q && (occ_q == 2'd0)) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (fifo_read_en) pops_d = pops_q + PW'(1);
    if (rd_pend_q) begin
      if (row_end) begin
        win_d      = '0;
        byte_cnt_d = '0;
        row_cnt_d  = row_cnt_q + RW'(1);
      end else begin
        win_d      = win_next;
        byte_cnt_d = byte_cnt_q + BW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      w_q        <= '0;
      win_q      <= '0;
      pops_q     <= '0;
      byte_cnt_q <= '0;
      row_cnt_q  <= '0;
      rd_pend_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      w_q        <= w_d;
      win_q      <= win_d;
      pops_q     <= pops_d;
      byte_cnt_q <= byte_cnt_d;
      row_cnt_q  <= row_cnt_d;
      rd_pend_q  <= fifo_read_en;
    end
  end

  // Out buffer: push on a completed window, pop on handshake, both allowed in one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_data_q[0] <= '0;
      buf_data_q[1] <= '0;
      buf_last_q    <= '0;
      wr_ptr_q      <= 1'b0;
      rd_ptr_q      <= 1'b0;
      occ_q         <= 2'd0;
    end else begin
      if (push) begin
        buf_data_q[wr_ptr_q] <= mac_res;
        buf_last_q[wr_ptr_q] <= row_end;
        wr_ptr_q             <= ~wr_ptr_q;
      end
      if (out_pop) rd_ptr_q <= ~rd_ptr_q;
      case ({push, out_pop})
        2'b10:   occ_q <= occ_q + 2'd1;
        2'b01:   occ_q <= occ_q - 2'd1;
        default: occ_q <= occ_q;
      endcase
    end
  end

endmodule

// File: tb/tb_q_proj_window_mac.sv
// Scoreboard bench for q_proj_window_mac: bench-side FIFO source, reference MAC model and a
// per-cycle monitor that pops expected results on every accepted output.
module tb_q_proj_window_mac;

  localparam int DW = 8;
  localparam int K  = 3;
  localparam int RL = 7;
  localparam int NR = 4;
  localparam int AW = 20;
  localparam int RES_PER_JOB = NR * (RL - K + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [K*DW-1:0] weights;
  logic          fifo_empty = 1'b1;
  logic          fifo_read_en;
  logic [DW-1:0] fifo_read_data = '0;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_data;
  logic          out_last;
  logic          busy;
  logic          done;

  q_proj_window_mac #(
    .DATA_WIDTH(DW), .KERNEL(K), .ROW_LEN(RL), .NUM_ROWS(NR), .ACC_WIDTH(AW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .weights(weights),
    .fifo_empty(fifo_empty), .fifo_read_en(fifo_read_en), .fifo_read_data(fifo_read_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] data;
    logic          last;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] src_q[$];
  logic [AW-1:0] obs_q[$];
  logic [DW-1:0] job_bytes [RL*NR];
  int            n_checks = 0;
  int            n_pass   = 0;
  int            done_cnt = 0;
  int            last_cnt = 0;
  logic          force_empty = 1'b0;
  logic          pop_pending = 1'b0;
  logic          prev_stall  = 1'b0;
  logic [AW-1:0] prev_data   = '0;

  // One clock: monitor at the falling edge, then FIFO source response just after the rising edge.
  task automatic cycle();
    exp_t e;
    @(negedge clk);
    if (!rst) begin
      if (fifo_read_en) begin
        n_checks++;
        if (fifo_empty !== 1'b0) $display("FAIL pop_while_empty: fifo_empty=%b required 0", fifo_empty);
        else n_pass++;
      end
      if (prev_stall) begin
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== prev_data)
          $display("FAIL hold_stable: valid=%b data=%h required valid=1 data=%h", out_valid, out_data, prev_data);
        else n_pass++;
      end
      if (out_valid && out_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_result: data=%h last=%b required no result", out_data, out_last);
        end else begin
          e = exp_q.pop_front();
          if (out_data !== e.data || out_last !== e.last)
            $display("FAIL result: data=%h last=%b required data=%h last=%b", out_data, out_last, e.data, e.last);
          else n_pass++;
        end
        obs_q.push_back(out_data);
        if (out_last) last_cnt++;
      end
      if (done === 1'b1) done_cnt++;
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end else begin
      prev_stall = 1'b0;
    end
    pop_pending = fifo_read_en && !rst;
    @(posedge clk);
    #1;
    if (pop_pending && src_q.size() > 0) fifo_read_data = src_q.pop_front();
    fifo_empty = force_empty || (src_q.size() == 0);
  endtask

  task automatic set_empty(input logic v);
    force_empty = v;
    fifo_empty  = force_empty || (src_q.size() == 0);
  endtask

  task automatic fill_random();
    for (int i = 0; i < RL*NR; i++) job_bytes[i] = DW'($urandom_range(0, 255));
  endtask

  task automatic set_row0(input logic [RL*DW-1:0] row);
    for (int i = 0; i < RL; i++) job_bytes[i] = row[(RL-1-i)*DW +: DW];
  endtask

  // Reference model: direct convolution over each row, independent of any window register.
  task automatic queue_job(input logic [K*DW-1:0] w);
    exp_t          e;
    int            s;
    logic [DW-1:0] wk;
    logic [DW-1:0] xb;
    for (int r = 0; r < NR; r++) begin
      for (int j = 0; j <= RL - K; j++) begin
        s = 0;
        for (int k = 0; k < K; k++) begin
          wk = w[k*DW +: DW];
          xb = job_bytes[r*RL + j + k];
          s  = s + int'($signed(wk)) * int'($signed(xb));
        end
        e.data = AW'(s);
        e.last = (j == RL - K);
        exp_q.push_back(e);
      end
    end
    for (int i = 0; i < RL*NR; i++) src_q.push_back(job_bytes[i]);
    obs_q.delete();
    last_cnt = 0;
    done_cnt = 0;
    fifo_empty = force_empty || (src_q.size() == 0);
  endtask

  task automatic start_job(input logic [K*DW-1:0] w);
    weights = w;
    start   = 1'b1;
    cycle();
    start   = 1'b0;
    weights = ~w;
  endtask

  task automatic wait_obs(input int n);
    int c = 0;
    while (obs_q.size() < n && c < 300) begin
      cycle();
      c++;
    end
    n_checks++;
    if (obs_q.size() < n) $display("FAIL wait_results: got=%0d required>=%0d", obs_q.size(), n);
    else n_pass++;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (done_cnt == 0 && cyc < 500) begin
      cycle();
      cyc++;
    end
    n_checks++;
    if (done_cnt == 0) $display("FAIL done_timeout: cycles=%0d required done within 500", cyc);
    else n_pass++;
    cycle();
    cycle();
    n_checks++;
    if (done_cnt !== 1) $display("FAIL done_pulses: count=%0d required 1", done_cnt);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) $display("FAIL idle_after_done: busy=%b done=%b required 0 0", busy, done);
    else n_pass++;
    n_checks++;
    if (exp_q.size() !== 0) $display("FAIL leftover_expected: count=%0d required 0", exp_q.size());
    else n_pass++;
    n_checks++;
    if (last_cnt !== NR) $display("FAIL last_count: count=%0d required %0d", last_cnt, NR);
    else n_pass++;
  endtask

  task automatic check_outputs_zero(input string tag);
    n_checks++;
    if ({fifo_read_en, out_valid, out_data, out_last, busy, done} !== '0)
      $display("FAIL %s: rd_en=%b valid=%b data=%h last=%b busy=%b done=%b required all 0",
               tag, fifo_read_en, out_valid, out_data, out_last, busy, done);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    weights = '0;
    out_ready = 1'b1;
    #1;
    check_outputs_zero("reset_state");
    cycle();
    cycle();
    check_outputs_zero("reset_hold");
    rst = 1'b0;
    cycle();
    check_outputs_zero("idle_after_reset");
  endtask

  task automatic test_basic();
    int cyc;
    fill_random();
    set_row0({8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h00, 8'h00});
    queue_job({8'd3, 8'd2, 8'd1});
    start_job({8'd3, 8'd2, 8'd1});
    n_checks++;
    if (busy !== 1'b1) $display("FAIL busy_in_run: busy=%b required 1", busy);
    else n_pass++;
    wait_done(cyc);
    n_checks++;
    if (obs_q.size() < 5 || obs_q[0] !== 20'd8 || obs_q[3] !== 20'd11 || obs_q[4] !== 20'd4)
      $display("FAIL basic_values: r0=%0d r3=%0d r4=%0d required 8 11 4", obs_q[0], obs_q[3], obs_q[4]);
    else n_pass++;
  endtask

  task automatic test_signed();
    int cyc;
    logic [AW-1:0] neg_exp;
    neg_exp = 20'hFC180;
    fill_random();
    set_row0({8'hFF, 8'hFF, 8'hFF, 8'h7F, 8'h80, 8'h00, 8'h00});
    queue_job({8'h80, 8'h80, 8'h80});
    start_job({8'h80, 8'h80, 8'h80});
    wait_done(cyc);
    n_checks++;
    if (obs_q.size() < 2 || obs_q[0] !== 20'd384 || obs_q[1] !== neg_exp)
      $display("FAIL signed_values: r0=%h r1=%h required %h %h", obs_q[0], obs_q[1], 20'd384, neg_exp);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    int cyc;
    fill_random();
    queue_job(24'h05_FD_7E);
    start_job(24'h05_FD_7E);
    wait_obs(2);
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (i >= 3) begin
        n_checks++;
        if (fifo_read_en !== 1'b0 || out_valid !== 1'b1)
          $display("FAIL stall_%0d: rd_en=%b valid=%b required 0 1", i, fifo_read_en, out_valid);
        else n_pass++;
      end
    end
    out_ready = 1'b1;
    wait_done(cyc);
  endtask

  task automatic test_underflow();
    int cyc;
    fill_random();
    queue_job(24'h81_40_C3);
    start_job(24'h81_40_C3);
    wait_obs(2);
    set_empty(1'b1);
    for (int i = 0; i < 5; i++) begin
      cycle();
      n_checks++;
      if (fifo_read_en !== 1'b0) $display("FAIL empty_%0d: rd_en=%b required 0", i, fifo_read_en);
      else n_pass++;
    end
    set_empty(1'b0);
    wait_done(cyc);
  endtask

  task automatic test_reset_mid();
    int cyc;
    fill_random();
    queue_job(24'h11_E2_33);
    start_job(24'h11_E2_33);
    wait_obs(7);
    rst = 1'b1;
    #1;
    check_outputs_zero("async_reset_mid");
    exp_q.delete();
    src_q.delete();
    pop_pending = 1'b0;
    cycle();
    check_outputs_zero("reset_mid_next");
    rst = 1'b0;
    cycle();
    fill_random();
    queue_job(24'h7F_80_01);
    start_job(24'h7F_80_01);
    wait_done(cyc);
    n_checks++;
    if (obs_q.size() !== RES_PER_JOB) $display("FAIL post_reset_count: got=%0d required %0d", obs_q.size(), RES_PER_JOB);
    else n_pass++;
  endtask

  task automatic test_start_ignored();
    int cyc;
    fill_random();
    queue_job(24'h02_03_04);
    start_job(24'h02_03_04);
    wait_obs(3);
    weights = 24'hAA_55_F0;
    start   = 1'b1;
    cycle();
    start   = 1'b0;
    wait_done(cyc);
  endtask

  task automatic test_back_to_back();
    int cyc;
    for (int j = 0; j < 2; j++) begin
      fill_random();
      queue_job(24'(32'h00C0_7F01 + j * 32'h0001_0203));
      start_job(24'(32'h00C0_7F01 + j * 32'h0001_0203));
      wait_done(cyc);
      n_checks++;
      if (cyc > 36) $display("FAIL throughput_%0d: cycles=%0d required <=36", j, cyc);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signed();
    test_backpressure();
    test_underflow();
    test_reset_mid();
    test_start_ignored();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
